regfile_wb: RTL

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb_pkg.sv | 37 +++
 rtl/wb_fifo.sv | 69 ++++++
 rtl/regfile_wb.sv | 98 +++++++++
 3 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared widths, payload type and read-port helper for the writeback register file.
package regfile_wb_pkg;

    localparam int unsigned REG_ADDR   = 5;
    localparam int unsigned REG_SIZE   = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

    typedef logic [REG_ADDR-1:0] reg_addr_t;
    typedef logic [REG_SIZE-1:0] reg_data_t;

    // One buffered multiply writeback.
    typedef struct packed {
        reg_addr_t dest;
        reg_data_t data;
    } wb_entry_t;

    // Register 0 is hardwired; otherwise this cycle's commit bypasses the bank.
    function automatic reg_data_t read_port(
        input reg_addr_t addr,
        input logic      commit_en,
        input reg_addr_t commit_dest,
        input reg_data_t commit_data,
        input reg_data_t bank_data
    );
        if (addr == '0) begin
            return '0;
        end
        if (commit_en && (commit_dest == addr)) begin
            return commit_data;
        end
        return bank_data;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small in-order buffer for multiply writebacks that could not commit directly.
module wb_fifo
    import regfile_wb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_push,
    input  wb_entry_t           i_push_entry,
    input  logic                i_pop,
    input  logic [REG_ADDR-1:0] i_match_addr1,
    input  logic [REG_ADDR-1:0] i_match_addr2,
    output wb_entry_t           o_head_c,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_match1_c,
    output logic                o_match2_c
);

    wb_entry_t              r_entry [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    // Storage, pointers and occupancy; pop clears before push so a same-cycle pair keeps order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            if (i_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push) begin
                r_entry[r_wr_ptr] <= i_push_entry;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Any valid entry (including one draining now) whose dest matches a nonzero read address.
    always_comb begin
        o_match1_c = 1'b0;
        o_match2_c = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_valid[i] && (r_entry[i].dest == i_match_addr1) && (i_match_addr1 != '0)) begin
                o_match1_c = 1'b1;
            end
            if (r_valid[i] && (r_entry[i].dest == i_match_addr2) && (i_match_addr2 != '0)) begin
                o_match2_c = 1'b1;
            end
        end
    end

    assign o_head_c = r_entry[r_rd_ptr];
    assign o_count  = r_count;

endmodule

// File: rtl/regfile_wb.sv
// 32-entry register file arbitrating main-pipeline and multiply writebacks, one commit per cycle.
module regfile_wb
    import regfile_wb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_ADDR-1:0] src_reg1,
    input  logic [REG_ADDR-1:0] src_reg2,
    output logic [REG_SIZE-1:0] rdata1,
    output logic [REG_SIZE-1:0] rdata2,
    output logic                pend1,
    output logic                pend2,
    input  logic                wb_regwrite,
    input  logic [REG_ADDR-1:0] wb_dest_reg,
    input  logic [REG_SIZE-1:0] wb_data,
    input  logic                mul_regwrite,
    input  logic [REG_ADDR-1:0] mul_dest_reg,
    input  logic [REG_SIZE-1:0] mul_data,
    output logic                mul_stall,
    output logic [CNT_W-1:0]    fifo_count
);

    logic [REG_SIZE-1:0] r_bank [NUM_REGS];

    logic             w_main_valid;
    logic             w_mul_valid;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    wb_entry_t        w_push_entry;
    wb_entry_t        w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_commit_en;
    reg_addr_t        w_commit_dest;
    reg_data_t        w_commit_data;

    // Writes to register 0 are dropped; a stalled multiply request is ignored.
    assign w_main_valid = wb_regwrite && (wb_dest_reg != '0);
    assign w_mul_valid  = mul_regwrite && (mul_dest_reg != '0) && !mul_stall;
    assign w_fifo_empty = (w_count == '0);
    assign mul_stall    = (w_count == CNT_W'(FIFO_DEPTH));
    assign fifo_count   = w_count;

    // Multiply writes that lose arbitration or would overtake buffered ones are queued.
    assign w_push       = w_mul_valid && (w_main_valid || !w_fifo_empty);
    assign w_push_entry = '{dest: mul_dest_reg, data: mul_data};

    // Select the single commit for this cycle: main, then buffer head, then direct multiply.
    always_comb begin
        w_commit_en   = 1'b0;
        w_commit_dest = '0;
        w_commit_data = '0;
        w_pop         = 1'b0;
        if (w_main_valid) begin
            w_commit_en   = 1'b1;
            w_commit_dest = wb_dest_reg;
            w_commit_data = wb_data;
        end else if (!w_fifo_empty) begin
            w_commit_en   = 1'b1;
            w_commit_dest = w_head.dest;
            w_commit_data = w_head.data;
            w_pop         = 1'b1;
        end else if (w_mul_valid) begin
            w_commit_en   = 1'b1;
            w_commit_dest = mul_dest_reg;
            w_commit_data = mul_data;
        end
    end

    wb_fifo u_wb_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_match_addr1(src_reg1),
        .i_match_addr2(src_reg2),
        .o_head_c     (w_head),
        .o_count      (w_count),
        .o_match1_c   (pend1),
        .o_match2_c   (pend2)
    );

    // Register bank: cleared on reset, one write per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_commit_en) begin
            r_bank[w_commit_dest] <= w_commit_data;
        end
    end

    assign rdata1 = read_port(src_reg1, w_commit_en, w_commit_dest, w_commit_data, r_bank[src_reg1]);
    assign rdata2 = read_port(src_reg2, w_commit_en, w_commit_dest, w_commit_data, r_bank[src_reg2]);

endmodule
